// File: rtl/beta_pkg.sv
// Shared types and constants for the beta core and its boot-time loader.
package beta_pkg;

    typedef enum logic [2:0] {
        HDR_HI = 3'd0,
        HDR_LO = 3'd1,
        DATA   = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } loader_state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/byte_to_word.sv
// Big-endian byte-to-word assembler: shifts bytes in MSB first and flags the
// byte that completes a word, so the caller can register the finished word.
module byte_to_word
    import beta_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      valid_i,
    input  logic [7:0]                byte_i,
    output logic [8*WORD_BYTES-1:0]   word_o,
    output logic                      word_done_o
);
    localparam int CW = $clog2(WORD_BYTES);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [8*WORD_BYTES-1:0] shift_q, shift_d;

    // The completed word includes the byte arriving this cycle.
    assign word_o      = {shift_q[8*WORD_BYTES-9:0], byte_i};
    assign word_done_o = valid_i && (cnt_q == CW'(WORD_BYTES - 1));

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear_i) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (valid_i) begin
            cnt_d   = cnt_q + CW'(1);
            shift_d = word_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a framed byte stream into instruction-memory writes and
// holds the processor in reset until a frame with a matching checksum lands.
module imem_loader
    import beta_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [31:0]           im_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);
    localparam logic [16:0] CAP = 17'(2**ADDR_WIDTH);

    loader_state_t         state_q, state_d;
    logic [7:0]            cnt_hi_q, cnt_hi_d;
    logic [15:0]           count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;
    logic [7:0]            chk_q, chk_d;
    logic                  im_we_q, im_we_d;
    logic [ADDR_WIDTH-1:0] im_addr_q, im_addr_d;
    logic [31:0]           im_wdata_q, im_wdata_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  cpu_reset_q, cpu_reset_d;

    logic        fire, rearm, b2w_valid, word_done, last_word;
    logic [31:0] word;
    logic [15:0] hdr_n;

    assign in_ready  = (state_q != DONE) && (state_q != ERROR);
    assign fire      = in_valid && in_ready;
    assign rearm     = start && !in_ready;
    assign b2w_valid = fire && (state_q == DATA);
    assign hdr_n     = {cnt_hi_q, in_data};
    assign last_word = (17'(words_q) + 17'd1) == {1'b0, count_q};

    byte_to_word u_b2w (
        .clk_i       (clk),
        .rst_i       (RESET),
        .clear_i     (rearm),
        .valid_i     (b2w_valid),
        .byte_i      (in_data),
        .word_o      (word),
        .word_done_o (word_done)
    );

    always_comb begin
        state_d     = state_q;
        cnt_hi_d    = cnt_hi_q;
        count_d     = count_q;
        addr_d      = addr_q;
        words_d     = words_q;
        chk_d       = chk_q;
        im_we_d     = 1'b0;
        im_addr_d   = im_addr_q;
        im_wdata_d  = im_wdata_q;
        done_d      = done_q;
        error_d     = error_q;
        cpu_reset_d = cpu_reset_q;
        case (state_q)
            HDR_HI: if (fire) begin
                cnt_hi_d = in_data;
                state_d  = HDR_LO;
            end
            HDR_LO: if (fire) begin
                count_d = hdr_n;
                if ({1'b0, hdr_n} > CAP) begin
                    state_d = ERROR;
                    error_d = 1'b1;
                end else if (hdr_n == 16'd0) begin
                    state_d = CHECK;
                end else begin
                    state_d = DATA;
                end
            end
            DATA: if (fire) begin
                chk_d = chk_q ^ in_data;
                if (word_done) begin
                    im_we_d    = 1'b1;
                    im_addr_d  = addr_q;
                    im_wdata_d = word;
                    addr_d     = addr_q + ADDR_WIDTH'(1);
                    words_d    = words_q + (ADDR_WIDTH+1)'(1);
                    if (last_word) state_d = CHECK;
                end
            end
            CHECK: if (fire) begin
                if (in_data == chk_q) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    cpu_reset_d = 1'b0;
                end else begin
                    state_d = ERROR;
                    error_d = 1'b1;
                end
            end
            DONE, ERROR: if (start) begin
                // Memory contents are left alone; only loader bookkeeping resets.
                state_d     = HDR_HI;
                count_d     = '0;
                addr_d      = '0;
                words_d     = '0;
                chk_d       = '0;
                im_addr_d   = '0;
                done_d      = 1'b0;
                error_d     = 1'b0;
                cpu_reset_d = 1'b1;
            end
            default: state_d = HDR_HI;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q     <= HDR_HI;
            cnt_hi_q    <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            words_q     <= '0;
            chk_q       <= '0;
            im_we_q     <= 1'b0;
            im_addr_q   <= '0;
            im_wdata_q  <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_hi_q    <= cnt_hi_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            words_q     <= words_d;
            chk_q       <= chk_d;
            im_we_q     <= im_we_d;
            im_addr_q   <= im_addr_d;
            im_wdata_q  <= im_wdata_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    assign im_we        = im_we_q;
    assign im_addr      = im_addr_q;
    assign im_wdata     = im_wdata_q;
    assign done         = done_q;
    assign error        = error_q;
    assign cpu_reset    = cpu_reset_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed frames against imem_loader with a frame-level model of expected
// memory writes and final status.
module tb_imem_loader;
    localparam int AW  = 4;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          RESET, start, in_valid;
    logic [7:0]    in_data;
    logic          in_ready, im_we, cpu_reset, done, error;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic [AW:0]   words_loaded;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .RESET(RESET), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_reset(cpu_reset), .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] a; logic [31:0] d; } wr_t;
    wr_t         expq[$];
    logic [31:0] wq[$];
    logic [7:0]  model_chk;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Per-cycle invariants and write-port checks against the expected write list.
    always @(negedge clk) begin
        if (!RESET) begin
            check("in_ready_vs_status", in_ready, !(done || error));
            check("cpu_reset_vs_done", cpu_reset, !done);
            if (im_we) begin
                check("we_expected", expq.size() > 0, 1);
                if (expq.size() > 0) begin
                    wr_t e;
                    e = expq.pop_front();
                    check("im_addr", im_addr, e.a);
                    check("im_wdata", im_wdata, e.d);
                end
            end
        end
    end

    // Builds the byte stream from header value n and the words in wq, queues
    // the writes that must appear, and drives it. abort_after >= 0 stops after
    // that many payload bytes.
    task automatic run_frame(input int n, input logic [7:0] flip, input bit stall, input int abort_after);
        logic [7:0] bq[$];
        logic [7:0] c, b;
        int nw;
        c = 8'h00;
        bq.push_back(n[15:8]);
        bq.push_back(n[7:0]);
        for (int i = 0; i < wq.size(); i++)
            for (int k = 3; k >= 0; k--) begin
                b = wq[i][8*k +: 8];
                bq.push_back(b);
                c ^= b;
            end
        model_chk = c;
        if (n > CAP) begin
            while (bq.size() > 2) void'(bq.pop_back());
            nw = 0;
        end else begin
            bq.push_back(c ^ flip);
            nw = (abort_after >= 0) ? abort_after / 4 : n;
        end
        for (int i = 0; i < nw; i++) expq.push_back('{a: AW'(i), d: wq[i]});
        for (int j = 0; j < bq.size(); j++) begin
            if (abort_after >= 0 && j == 2 + abort_after) return;
            if (stall && (j % 2 == 1)) begin
                @(negedge clk);
                in_valid = 1'b0;
                start    = (j == 3);
            end
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b1;
            in_data  = bq[j];
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rearm_done", done, 0);
        check("rearm_error", error, 0);
        check("rearm_cpu_reset", cpu_reset, 1);
        check("rearm_words", words_loaded, 0);
        check("rearm_in_ready", in_ready, 1);
    endtask

    task automatic check_end(input string nm, input bit exp_done, input int exp_words);
        check({nm, "_done"}, done, exp_done);
        check({nm, "_error"}, error, !exp_done);
        check({nm, "_cpu_reset"}, cpu_reset, !exp_done);
        check({nm, "_in_ready"}, in_ready, 0);
        check({nm, "_words"}, words_loaded, exp_words);
        check({nm, "_writes_left"}, expq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_im_we", im_we, 0);
        check("rst_im_addr", im_addr, 0);
        check("rst_im_wdata", im_wdata, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_words", words_loaded, 0);
        RESET = 1'b0;

        // Ten words 0..9, good checksum.
        wq.delete();
        for (int i = 0; i < 10; i++) wq.push_back(32'(i));
        run_frame(10, 8'h00, 1'b0, -1);
        check("model_chk_10", model_chk, 8'h01);
        check_end("load10", 1'b1, 10);

        // Same frame, corrupted checksum: writes still happen.
        pulse_start();
        run_frame(10, 8'h01, 1'b0, -1);
        check_end("badchk", 1'b0, 10);

        // Header one past capacity is rejected right after COUNT_LO.
        pulse_start();
        wq.delete();
        run_frame(CAP + 1, 8'h00, 1'b0, -1);
        check_end("overflow", 1'b0, 0);

        // Exactly full memory is accepted.
        pulse_start();
        wq.delete();
        for (int i = 0; i < CAP; i++) wq.push_back(32'hA5000000 + 32'(i) * 32'h01010101);
        run_frame(CAP, 8'h00, 1'b0, -1);
        check_end("full", 1'b1, CAP);

        // Empty frame.
        pulse_start();
        wq.delete();
        run_frame(0, 8'h00, 1'b0, -1);
        check_end("empty", 1'b1, 0);

        // Two words with a bubble every other byte and a stray start mid-frame.
        pulse_start();
        wq.delete();
        wq.push_back(32'hDEADBEEF);
        wq.push_back(32'h01234567);
        run_frame(2, 8'h00, 1'b1, -1);
        check("model_chk_2", model_chk, 8'h22);
        check_end("stall", 1'b1, 2);

        // Abort with RESET after six payload bytes (one word written).
        pulse_start();
        wq.delete();
        for (int i = 0; i < 10; i++) wq.push_back(32'h00000100 + 32'(i));
        run_frame(10, 8'h00, 1'b0, 6);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_abort_words", words_loaded, 1);
        #1 RESET = 1'b1; start = 1'b1;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_im_we", im_we, 0);
        check("abort_im_addr", im_addr, 0);
        check("abort_im_wdata", im_wdata, 0);
        check("abort_cpu_reset", cpu_reset, 1);
        check("abort_done", done, 0);
        check("abort_error", error, 0);
        check("abort_words", words_loaded, 0);
        check("abort_writes_left", expq.size(), 0);
        @(negedge clk);
        start = 1'b0;
        RESET = 1'b0;

        // Fresh frame after reset loads from address 0.
        wq.delete();
        for (int i = 0; i < 3; i++) wq.push_back(32'hC0DE0000 + 32'(i));
        run_frame(3, 8'h00, 1'b0, -1);
        check_end("reload", 1'b1, 3);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
